// File: rtl/game_director_if.sv
// Bundles the frame, control and collision-box signals of the game loop director.
// The master side drives the game inputs; the slave side is the director itself.
interface game_director_if #(
    parameter int FPS     = 60,
    parameter int SPEED_W = 15,
    parameter int A_BOXES = 4,
    parameter int B_BOXES = 4,
    parameter int COORD_W = 12
);
    logic                           painter_finished;
    logic                           jump;
    logic                           pause_req;
    logic [A_BOXES*4*COORD_W-1:0]   a_boxes;
    logic [B_BOXES*4*COORD_W-1:0]   b_boxes;

    logic                           update;
    logic [$clog2(FPS)-1:0]         timer;
    logic [1:0]                     state;
    logic [SPEED_W-1:0]             speed;
    logic                           start;
    logic                           restart;
    logic                           has_obstacles;
    logic                           rng_load;
    logic                           crash;

    modport master (
        output painter_finished, jump, pause_req, a_boxes, b_boxes,
        input  update, timer, state, speed, start, restart, has_obstacles, rng_load, crash
    );

    modport slave (
        input  painter_finished, jump, pause_req, a_boxes, b_boxes,
        output update, timer, state, speed, start, restart, has_obstacles, rng_load, crash
    );
endinterface

// File: rtl/game_director.sv
// Runner game loop: frame pulse/timer, WAITING/RUNNING/PAUSED/CRASHED FSM,
// speed ramp, obstacle clear-time gating and player/obstacle AABB collision.
module game_director #(
    parameter int FPS            = 60,
    parameter int SPEED_W        = 15,
    parameter int INIT_SPEED     = 6144,
    parameter int MAX_SPEED      = 13312,
    parameter int ACCEL          = 1,
    parameter int CLEAR_FRAMES   = 180,
    parameter int RESTART_FRAMES = 45,
    parameter int A_BOXES        = 4,
    parameter int B_BOXES        = 4,
    parameter int COORD_W        = 12
) (
    input  logic            clk,
    input  logic            rst,
    game_director_if.slave  gd
);
    localparam int TIMER_W = $clog2(FPS);
    localparam int CLR_W   = $clog2(CLEAR_FRAMES + 1);
    localparam int CD_W    = $clog2(RESTART_FRAMES + 1);
    localparam int BOX_W   = 4 * COORD_W;

    localparam logic [1:0] ST_WAITING = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_CRASHED = 2'd3;

    localparam logic [SPEED_W:0]   LP_MAX_SPEED = (SPEED_W+1)'(MAX_SPEED);
    localparam logic [SPEED_W:0]   LP_ACCEL     = (SPEED_W+1)'(ACCEL);
    localparam logic [SPEED_W-1:0] LP_INIT      = SPEED_W'(INIT_SPEED);
    localparam logic [CLR_W-1:0]   LP_CLEAR     = CLR_W'(CLEAR_FRAMES);
    localparam logic [CD_W-1:0]    LP_COOLDOWN  = CD_W'(RESTART_FRAMES);
    localparam logic [TIMER_W-1:0] LP_TIMER_MAX = TIMER_W'(FPS - 1);

    logic                   r_pf_d, r_pause_d, r_update, r_start, r_restart, r_has_obs, r_rng_load;
    logic [TIMER_W-1:0]     r_timer;
    logic [1:0]             r_state;
    logic [SPEED_W-1:0]     r_speed;
    logic [CLR_W-1:0]       r_clear;
    logic [CD_W-1:0]        r_cooldown;

    logic                   w_frame, w_pause_edge, w_crash;
    logic [SPEED_W:0]       w_speed_sum;
    logic [SPEED_W-1:0]     w_speed_next;
    logic [A_BOXES-1:0][B_BOXES-1:0] w_hit;

    assign w_frame      = gd.painter_finished & ~r_pf_d;
    assign w_pause_edge = gd.pause_req & ~r_pause_d;
    assign w_speed_sum  = {1'b0, r_speed} + LP_ACCEL;
    assign w_speed_next = (w_speed_sum > LP_MAX_SPEED) ? LP_MAX_SPEED[SPEED_W-1:0]
                                                       : w_speed_sum[SPEED_W-1:0];

    // Box fields are sign-extended to COORD_W+1 so the edge sums cannot wrap.
    for (genvar i = 0; i < A_BOXES; i++) begin : g_a
        for (genvar j = 0; j < B_BOXES; j++) begin : g_b
            logic signed [COORD_W:0] w_ax, w_ay, w_aw, w_ah, w_bx, w_by, w_bw, w_bh;
            assign w_ax = {gd.a_boxes[i*BOX_W+4*COORD_W-1], gd.a_boxes[i*BOX_W+3*COORD_W +: COORD_W]};
            assign w_ay = {gd.a_boxes[i*BOX_W+3*COORD_W-1], gd.a_boxes[i*BOX_W+2*COORD_W +: COORD_W]};
            assign w_aw = {gd.a_boxes[i*BOX_W+2*COORD_W-1], gd.a_boxes[i*BOX_W+1*COORD_W +: COORD_W]};
            assign w_ah = {gd.a_boxes[i*BOX_W+1*COORD_W-1], gd.a_boxes[i*BOX_W +: COORD_W]};
            assign w_bx = {gd.b_boxes[j*BOX_W+4*COORD_W-1], gd.b_boxes[j*BOX_W+3*COORD_W +: COORD_W]};
            assign w_by = {gd.b_boxes[j*BOX_W+3*COORD_W-1], gd.b_boxes[j*BOX_W+2*COORD_W +: COORD_W]};
            assign w_bw = {gd.b_boxes[j*BOX_W+2*COORD_W-1], gd.b_boxes[j*BOX_W+1*COORD_W +: COORD_W]};
            assign w_bh = {gd.b_boxes[j*BOX_W+1*COORD_W-1], gd.b_boxes[j*BOX_W +: COORD_W]};
            assign w_hit[i][j] = (w_aw != 0) && (w_ah != 0) && (w_bw != 0) && (w_bh != 0) &&
                                 (w_ax < w_bx + w_bw) && (w_bx < w_ax + w_aw) &&
                                 (w_ay < w_by + w_bh) && (w_by < w_ay + w_ah);
        end
    end

    assign w_crash = |w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_d     <= 1'b0;
            r_pause_d  <= 1'b0;
            r_update   <= 1'b0;
            r_timer    <= '0;
            r_state    <= ST_WAITING;
            r_speed    <= '0;
            r_start    <= 1'b0;
            r_restart  <= 1'b0;
            r_has_obs  <= 1'b0;
            r_rng_load <= 1'b1;
            r_clear    <= '0;
            r_cooldown <= '0;
        end else begin
            r_pf_d    <= gd.painter_finished;
            r_update  <= w_frame && (r_state != ST_PAUSED);
            r_restart <= 1'b0;
            if (w_frame) begin
                r_timer   <= (r_timer == LP_TIMER_MAX) ? '0 : r_timer + 1'b1;
                r_pause_d <= gd.pause_req;
            end
            case (r_state)
                ST_WAITING: if (w_frame && gd.jump) begin
                    r_state    <= ST_RUNNING;
                    r_speed    <= LP_INIT;
                    r_start    <= 1'b1;
                    r_rng_load <= 1'b0;
                end
                ST_RUNNING: begin
                    // Collision is checked every cycle, not only on frame events.
                    if (w_crash) begin
                        r_state    <= ST_CRASHED;
                        r_cooldown <= LP_COOLDOWN;
                    end else if (w_frame && w_pause_edge) begin
                        r_state <= ST_PAUSED;
                    end else if (w_frame) begin
                        r_speed <= w_speed_next;
                        if (r_clear != LP_CLEAR) r_clear <= r_clear + 1'b1;
                        if (r_clear >= LP_CLEAR) r_has_obs <= 1'b1;
                    end
                end
                ST_PAUSED: if (w_frame && w_pause_edge) r_state <= ST_RUNNING;
                default: if (w_frame) begin
                    if (r_cooldown == '0 && gd.jump) begin
                        r_state   <= ST_RUNNING;
                        r_restart <= 1'b1;
                        r_speed   <= LP_INIT;
                        r_clear   <= '0;
                        r_has_obs <= 1'b0;
                    end else if (r_cooldown != '0) begin
                        r_cooldown <= r_cooldown - 1'b1;
                    end
                end
            endcase
        end
    end

    assign gd.update        = r_update;
    assign gd.timer         = r_timer;
    assign gd.state         = r_state;
    assign gd.speed         = r_speed;
    assign gd.start         = r_start;
    assign gd.restart       = r_restart;
    assign gd.has_obstacles = r_has_obs;
    assign gd.rng_load      = r_rng_load;
    assign gd.crash         = w_crash;
endmodule
